// File: rtl/lia_iq_integrator.sv
// Lock-in I/Q integrate-and-dump.
// Sums mixer products over a window of N valid samples. Each completed window
// yields one decimated, shifted and saturated X/Y result. The result is held
// on a valid/ready interface until the downstream side takes it.
module lia_iq_integrator #(
    parameter int unsigned MIXER_WIDTH = 24,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH   = 40,
    parameter int unsigned OUT_WIDTH   = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic signed [MIXER_WIDTH-1:0] mixer_i_in,
    input  logic signed [MIXER_WIDTH-1:0] mixer_q_in,
    input  logic                          mixer_valid,
    input  logic        [CNT_WIDTH-1:0]   dec_len,
    input  logic        [5:0]             out_shift,
    output logic signed [OUT_WIDTH-1:0]   x_out,
    output logic signed [OUT_WIDTH-1:0]   y_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overrun,
    input  logic                          overrun_clr
);

    localparam int unsigned EXT_WIDTH = ACC_WIDTH - MIXER_WIDTH;

    // Saturation bounds of the output word, expressed at accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                        state, state_n;
    logic signed [ACC_WIDTH-1:0]   acc_i, acc_q, acc_i_n, acc_q_n;
    logic        [CNT_WIDTH-1:0]   count, count_n, len_q, len_q_n;
    logic signed [OUT_WIDTH-1:0]   x_n, y_n;
    logic                          out_valid_n, overrun_n;

    logic signed [ACC_WIDTH-1:0]   sum_i_c, sum_q_c;
    logic        [CNT_WIDTH-1:0]   len_cur_c;
    logic                          last_c, dump_c;

    // Clamp a shifted window sum into the signed output range.
    function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[OUT_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[OUT_WIDTH-1:0];
        end
        return v[OUT_WIDTH-1:0];
    endfunction

    // Running sums including the current sample, and the window-end test.
    // On the first sample the live dec_len is used, so a length of 1 dumps at once.
    always_comb begin
        sum_i_c   = acc_i + {{EXT_WIDTH{mixer_i_in[MIXER_WIDTH-1]}}, mixer_i_in};
        sum_q_c   = acc_q + {{EXT_WIDTH{mixer_q_in[MIXER_WIDTH-1]}}, mixer_q_in};
        if (count == '0) begin
            len_cur_c = (dec_len == '0) ? CNT_WIDTH'(1) : dec_len;
        end else begin
            len_cur_c = len_q;
        end
        last_c = (count == len_cur_c - CNT_WIDTH'(1));
    end

    // Next-state and datapath update: FSM, accumulators, result hand-off.
    always_comb begin
        state_n     = state;
        acc_i_n     = acc_i;
        acc_q_n     = acc_q;
        count_n     = count;
        len_q_n     = len_q;
        x_n         = x_out;
        y_n         = y_out;
        out_valid_n = out_valid;
        overrun_n   = overrun;
        dump_c      = 1'b0;

        case (state)
            IDLE: begin
                acc_i_n = '0;
                acc_q_n = '0;
                count_n = '0;
                if (enable) begin
                    state_n = ACCUM;
                end
            end
            ACCUM: begin
                if (!enable) begin
                    // Partial window is dropped without producing a result.
                    state_n = IDLE;
                    acc_i_n = '0;
                    acc_q_n = '0;
                    count_n = '0;
                end else if (mixer_valid) begin
                    if (count == '0) begin
                        len_q_n = len_cur_c;
                    end
                    if (last_c) begin
                        dump_c  = 1'b1;
                        acc_i_n = '0;
                        acc_q_n = '0;
                        count_n = '0;
                    end else begin
                        acc_i_n = sum_i_c;
                        acc_q_n = sum_q_c;
                        count_n = count + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A new dump always wins over consumption of the held result.
        if (dump_c) begin
            x_n         = sat(sum_i_c >>> out_shift);
            y_n         = sat(sum_q_c >>> out_shift);
            out_valid_n = 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid_n = 1'b0;
        end

        // Clear first so a coincident overrun event takes precedence.
        if (overrun_clr) begin
            overrun_n = 1'b0;
        end
        if (dump_c && out_valid && !out_ready) begin
            overrun_n = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_i     <= '0;
            acc_q     <= '0;
            count     <= '0;
            len_q     <= CNT_WIDTH'(1);
            x_out     <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            acc_i     <= acc_i_n;
            acc_q     <= acc_q_n;
            count     <= count_n;
            len_q     <= len_q_n;
            x_out     <= x_n;
            y_out     <= y_n;
            out_valid <= out_valid_n;
            overrun   <= overrun_n;
        end
    end

endmodule

// File: tb/tb_lia_iq_integrator.sv
// Directed bench for lia_iq_integrator with hand-computed expected results.
module tb_lia_iq_integrator;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic signed [23:0] mixer_i_in;
    logic signed [23:0] mixer_q_in;
    logic               mixer_valid;
    logic        [15:0] dec_len;
    logic        [5:0]  out_shift;
    logic signed [23:0] x_out;
    logic signed [23:0] y_out;
    logic               out_valid;
    logic               out_ready;
    logic               overrun;
    logic               overrun_clr;

    int n_vec = 0;
    int n_err = 0;

    lia_iq_integrator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mixer_i_in  (mixer_i_in),
        .mixer_q_in  (mixer_q_in),
        .mixer_valid (mixer_valid),
        .dec_len     (dec_len),
        .out_shift   (out_shift),
        .x_out       (x_out),
        .y_out       (y_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leave the current window cleanly: abort any partial window, re-enter ACCUM.
    task automatic restart();
        mixer_valid = 1'b0;
        enable      = 1'b0;
        cyc();
        enable      = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; mixer_i_in = '0; mixer_q_in = '0; mixer_valid = 1'b0;
        dec_len = 16'd4; out_shift = 6'd0; out_ready = 1'b1; overrun_clr = 1'b0;
        #2;
        n_vec++; if (x_out !== 24'sd0) begin n_err++; $display("FAIL reset_x got=%0d exp=0", x_out); end
        n_vec++; if (y_out !== 24'sd0) begin n_err++; $display("FAIL reset_y got=%0d exp=0", y_out); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        dec_len = 16'd4; out_shift = 6'd0; out_ready = 1'b1;
        enable = 1'b1;
        cyc();
        mixer_i_in = 24'sd100; mixer_q_in = -24'sd50; mixer_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            n_vec++; if (out_valid !== (k % 4 == 0)) begin n_err++; $display("FAIL basic_valid k=%0d got=%b exp=%b", k, out_valid, (k % 4 == 0)); end
            if (k % 4 == 0) begin
                n_vec++; if (x_out !== 24'sd400) begin n_err++; $display("FAIL basic_x k=%0d got=%0d exp=400", k, x_out); end
                n_vec++; if (y_out !== -24'sd200) begin n_err++; $display("FAIL basic_y k=%0d got=%0d exp=-200", k, y_out); end
            end
        end
        restart();
    endtask

    task automatic test_sparse();
        dec_len = 16'd3; out_shift = 6'd0; out_ready = 1'b1; mixer_q_in = '0;
        for (int i = 1; i <= 6; i++) begin
            mixer_i_in = 24'(i); mixer_valid = 1'b1;
            cyc();
            mixer_valid = 1'b0;
            n_vec++; if (out_valid !== (i % 3 == 0)) begin n_err++; $display("FAIL sparse_valid i=%0d got=%b exp=%b", i, out_valid, (i % 3 == 0)); end
            if (i == 3) begin
                n_vec++; if (x_out !== 24'sd6) begin n_err++; $display("FAIL sparse_x1 got=%0d exp=6", x_out); end
            end
            if (i == 6) begin
                n_vec++; if (x_out !== 24'sd15) begin n_err++; $display("FAIL sparse_x2 got=%0d exp=15", x_out); end
            end
            cyc();
        end
        restart();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1; dec_len = 16'd4;
        for (int s = 0; s < 2; s++) begin
            out_shift = (s == 0) ? 6'd0 : 6'd2;
            mixer_i_in = 24'sh7FFFFF; mixer_q_in = 24'sh800000; mixer_valid = 1'b1;
            for (int k = 0; k < 4; k++) cyc();
            mixer_valid = 1'b0;
            n_vec++; if (x_out !== 24'sh7FFFFF) begin n_err++; $display("FAIL sat_x shift=%0d got=%h exp=7fffff", out_shift, x_out); end
            n_vec++; if (y_out !== 24'sh800000) begin n_err++; $display("FAIL sat_y shift=%0d got=%h exp=800000", out_shift, y_out); end
        end
        dec_len = 16'd1; out_shift = 6'd1;
        mixer_i_in = -24'sd5; mixer_q_in = 24'sd4; mixer_valid = 1'b1;
        cyc();
        mixer_valid = 1'b0;
        n_vec++; if (x_out !== -24'sd3) begin n_err++; $display("FAIL floor_x got=%0d exp=-3", x_out); end
        n_vec++; if (y_out !== 24'sd2) begin n_err++; $display("FAIL floor_y got=%0d exp=2", y_out); end
        out_shift = 6'd0;
        restart();
    endtask

    task automatic test_back_to_back();
        dec_len = 16'd1; out_shift = 6'd0; out_ready = 1'b1; mixer_q_in = '0;
        for (int i = 1; i <= 3; i++) begin
            mixer_i_in = 24'(i * 11); mixer_valid = 1'b1;
            cyc();
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid i=%0d got=%b exp=1", i, out_valid); end
            n_vec++; if (x_out !== 24'(i * 11)) begin n_err++; $display("FAIL b2b_x i=%0d got=%0d exp=%0d", i, x_out, i * 11); end
        end
        restart();
    endtask

    task automatic test_backpressure();
        dec_len = 16'd2; out_shift = 6'd0; out_ready = 1'b0; mixer_q_in = '0;
        mixer_valid = 1'b1;
        mixer_i_in = 24'sd5; cyc(); cyc();
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL bp_ovr_first got=%b exp=0", overrun); end
        mixer_i_in = 24'sd10; cyc(); cyc();
        mixer_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
        n_vec++; if (x_out !== 24'sd20) begin n_err++; $display("FAIL bp_x got=%0d exp=20", x_out); end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL bp_ovr got=%b exp=1", overrun); end
        overrun_clr = 1'b1; cyc(); overrun_clr = 1'b0;
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL bp_clr got=%b exp=0", overrun); end
        n_vec++; if (x_out !== 24'sd20) begin n_err++; $display("FAIL bp_hold got=%0d exp=20", x_out); end
        mixer_i_in = 24'sd3; mixer_valid = 1'b1;
        cyc();
        out_ready = 1'b1;
        cyc();
        mixer_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_same_edge_valid got=%b exp=1", out_valid); end
        n_vec++; if (x_out !== 24'sd6) begin n_err++; $display("FAIL bp_same_edge_x got=%0d exp=6", x_out); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL bp_same_edge_ovr got=%b exp=0", overrun); end
        cyc();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
        restart();
    endtask

    task automatic test_abort();
        dec_len = 16'd4; out_shift = 6'd0; out_ready = 1'b1; mixer_q_in = '0;
        mixer_i_in = 24'sd7; mixer_valid = 1'b1;
        cyc(); cyc();
        enable = 1'b0; cyc();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_no_result got=%b exp=0", out_valid); end
        enable = 1'b1; cyc();
        mixer_i_in = 24'sd1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            n_vec++; if (out_valid !== (k == 4)) begin n_err++; $display("FAIL abort_valid k=%0d got=%b exp=%b", k, out_valid, (k == 4)); end
        end
        mixer_valid = 1'b0;
        n_vec++; if (x_out !== 24'sd4) begin n_err++; $display("FAIL abort_x got=%0d exp=4", x_out); end
        restart();
    endtask

    task automatic test_async_reset();
        dec_len = 16'd2; out_shift = 6'd0; out_ready = 1'b0; mixer_q_in = 24'sd1;
        mixer_i_in = 24'sd9; mixer_valid = 1'b1;
        for (int k = 0; k < 5; k++) cyc();
        mixer_valid = 1'b0;
        n_vec++; if (overrun !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre got=%b%b exp=11", out_valid, overrun); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (x_out !== 24'sd0 || y_out !== 24'sd0) begin n_err++; $display("FAIL arst_xy got=%0d/%0d exp=0/0", x_out, y_out); end
        n_vec++; if (out_valid !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL arst_flags got=%b%b exp=00", out_valid, overrun); end
        rst_n = 1'b1; out_ready = 1'b1; enable = 1'b1;
        cyc();
        mixer_i_in = 24'sd1; mixer_valid = 1'b1;
        cyc();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_partial got=%b exp=0", out_valid); end
        cyc();
        mixer_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || x_out !== 24'sd2) begin n_err++; $display("FAIL arst_full got=%b/%0d exp=1/2", out_valid, x_out); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sparse();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
